branch_predictor: RTL and testbench
===================================

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter ENTRIES, default 64, meaning number of predictor entries; SHALL be a power of two from 4 to 1024.
REQ-002 Parameter XLEN, default 32, meaning address and data width.
REQ-003 Parameter CNT_INIT, default 2'b01, meaning the counter value loaded at reset and on clear (weakly not-taken).
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 if_pc  input  XLEN  fetch-stage PC to look up.
REQ-007 pred_taken  output  1  prediction for if_pc: 1 = redirect fetch.
REQ-008 pred_target  output  XLEN  predicted target; 0 when pred_taken=0.
REQ-009 upd_valid  input  1  EX-stage resolved branch or jump is present this cycle.
REQ-010 upd_pc  input  XLEN  PC of the resolved instruction.
REQ-011 upd_taken  input  1  actual outcome.
REQ-012 upd_target  input  XLEN  actual target (pc+imm, or rs1+imm for JALR).
REQ-013 upd_is_jump  input  1  instruction is JAL or JALR.
REQ-014 upd_pred_taken  input  1  prediction that was made for this instruction.
REQ-015 upd_pred_target  input  XLEN  predicted target that was made for this instruction.
REQ-016 clear  input  1  synchronous invalidate of all entries (for example FENCE.I).
REQ-017 mispredict  output  1  combinational; asserted when upd_valid=1 and the outcome differs from the prediction.
REQ-018 mispredict_count  output  32  wrapping count of mispredict cycles.
REQ-019 update_count  output  32  wrapping count of upd_valid cycles.

Function
REQ-020 Index SHALL be pc[IDX+1:2], where IDX=log2(ENTRIES); tag SHALL be pc[XLEN-1:IDX+2]; pc[1:0] SHALL be ignored.
REQ-021 Each entry SHALL hold: valid (1 bit), tag, target (XLEN), and a 2-bit saturating counter.
REQ-022 Lookup SHALL be combinational from registered state, with zero-cycle latency.
REQ-023 A hit occurs when the entry is valid and its tag matches; pred_taken SHALL equal hit AND counter[1].
REQ-024 When upd_valid=1 and upd_taken=1, the entry SHALL be written with valid=1, the tag, and upd_target.
REQ-025 On a taken non-jump with a tag match, the counter SHALL increment, saturating at 3.
REQ-026 On a taken non-jump that allocates a new entry, the counter SHALL load 2'b10.
REQ-027 When upd_valid=1, upd_taken=0 and the tag matches, the counter SHALL decrement, saturating at 0; tag and target SHALL be unchanged.
REQ-028 When upd_valid=1, upd_taken=0 and the tag does not match, the entry SHALL not change (no allocation on not-taken).
REQ-029 When upd_is_jump=1, the counter SHALL load 2'b11 regardless of its prior value.
REQ-030 mispredict SHALL equal upd_valid AND ((upd_taken != upd_pred_taken) OR (upd_taken AND upd_target != upd_pred_target)).
REQ-031 An update SHALL become visible to lookup on the cycle after the update cycle.
REQ-032 When a lookup and an update hit the same index in the same cycle, the lookup SHALL return the pre-update value (no bypass).
REQ-033 clear=1 SHALL zero all valid bits and set all counters to CNT_INIT at the next edge.
REQ-034 When clear and upd_valid are both 1 in the same cycle, clear SHALL win and the update SHALL be dropped.
REQ-035 The performance counters SHALL still count in a cycle where clear=1.
REQ-036 Both performance counters SHALL wrap from 32'hFFFFFFFF to 0 without sticking.

Reset
REQ-037 While rst_n=0, all valid bits SHALL be 0, all counters SHALL be CNT_INIT, and both performance counters SHALL be 0, asynchronously.
REQ-038 During and after reset, pred_taken SHALL be 0 and pred_target SHALL be 0.
REQ-039 Tag and target storage SHALL not require reset; their contents SHALL never be observable while valid=0.
REQ-040 Reset asserted mid-update SHALL abort the write, leaving the reset state.
REQ-041 Deassertion of reset SHALL take effect at a clock edge; the first legal update is the first edge after deassertion.

Structure
REQ-042 The counter encodings (SNT=0, WNT=1, WT=2, ST=3) and the derived IDX/TAG width functions SHALL live in the shared core package/header used by the pipeline.
REQ-043 One sub-module SHALL be used: bp_sat_counter, a 2-bit saturating next-state function taking inc, dec, load and load value.
REQ-044 Storage SHALL be flop arrays, not BRAM, so that lookup is zero-latency.

Verification
REQ-045 Reset, then if_pc=0x100 -> pred_taken=0, pred_target=0, both counters=0.
REQ-046 Update pc=0x100, taken, target=0x200, non-jump; next cycle if_pc=0x100 -> pred_taken=1, pred_target=0x200.
REQ-047 Same entry, two not-taken updates -> counter 2->1->0; if_pc=0x100 -> pred_taken=0; a third not-taken update holds the counter at 0.
REQ-048 Alias (ENTRIES=64): allocate 0x100 taken, then look up 0x200 (same index 0, different tag) -> pred_taken=0; a taken update at 0x200 replaces the entry, after which 0x100 misses.
REQ-049 Update pc=0x40, JAL, target=0x80, with clear=1 in the same cycle -> entry stays invalid, update_count=1; mispredict=1 when upd_pred_taken=0.
REQ-050 Preload mispredict_count=0xFFFFFFFF via 2^32-1 mispredicts, or a forced-value bench hook; one more mispredict -> count=0.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// ---------------------------------------------------------------------------
// branch_predictor_pkg
//   Shared definitions for the fetch-stage branch predictor:
//     bp_cnt_e  - 2-bit saturating counter encodings (SNT/WNT/WT/ST)
//     bp_idx_w  - number of index bits for a given entry count
//     bp_tag_w  - number of tag bits for a given address width / entry count
// ---------------------------------------------------------------------------
package branch_predictor_pkg;

    typedef enum logic [1:0] {
        SNT = 2'd0,
        WNT = 2'd1,
        WT  = 2'd2,
        ST  = 2'd3
    } bp_cnt_e;

    function automatic int unsigned bp_idx_w(input int unsigned entries);
        return $clog2(entries);
    endfunction

    // pc[1:0] is ignored, so the tag is whatever sits above the index.
    function automatic int unsigned bp_tag_w(input int unsigned xlen,
                                             input int unsigned entries);
        return xlen - $clog2(entries) - 2;
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// ---------------------------------------------------------------------------
// branch_predictor_if
//   Bundle between the pipeline and the branch predictor.
//   master (pipeline): drives if_pc, upd_* and clear; receives predictions,
//                      mispredict flag and performance counters.
//   slave  (predictor): the reverse.
// ---------------------------------------------------------------------------
interface branch_predictor_if #(
    parameter int unsigned XLEN = 32
);
    logic [XLEN-1:0] if_pc;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;
    logic            upd_valid;
    logic [XLEN-1:0] upd_pc;
    logic            upd_taken;
    logic [XLEN-1:0] upd_target;
    logic            upd_is_jump;
    logic            upd_pred_taken;
    logic [XLEN-1:0] upd_pred_target;
    logic            clear;
    logic            mispredict;
    logic [31:0]     mispredict_count;
    logic [31:0]     update_count;

    modport master (
        output if_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_is_jump,
               upd_pred_taken, upd_pred_target, clear,
        input  pred_taken, pred_target, mispredict, mispredict_count, update_count
    );

    modport slave (
        input  if_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_is_jump,
               upd_pred_taken, upd_pred_target, clear,
        output pred_taken, pred_target, mispredict, mispredict_count, update_count
    );
endinterface

// File: rtl/bp_sat_counter.sv
// ---------------------------------------------------------------------------
// bp_sat_counter
//   Next-state function of a 2-bit saturating counter.
//   cnt_i    - current value
//   inc/dec  - step up/down, saturating at ST/SNT
//   load     - overrides inc/dec with load_val
//   cnt_o    - next value
// ---------------------------------------------------------------------------
module bp_sat_counter
    import branch_predictor_pkg::*;
(
    input  bp_cnt_e cnt_i,
    input  logic    inc,
    input  logic    dec,
    input  logic    load,
    input  bp_cnt_e load_val,
    output bp_cnt_e cnt_o
);
    logic [1:0] cnt_up;
    logic [1:0] cnt_dn;

    always_comb begin
        cnt_up = cnt_i + 2'd1;
        cnt_dn = cnt_i - 2'd1;
        cnt_o  = cnt_i;
        if (load) begin
            cnt_o = load_val;
        end else if (inc && (cnt_i != ST)) begin
            cnt_o = bp_cnt_e'(cnt_up);
        end else if (dec && (cnt_i != SNT)) begin
            cnt_o = bp_cnt_e'(cnt_dn);
        end
    end
endmodule

// File: rtl/branch_predictor.sv
// ---------------------------------------------------------------------------
// branch_predictor
//   Direct-mapped BTB with 2-bit saturating direction counters.
//   clk, rst_n   - clock, asynchronous active-low reset
//   bp (slave)   - lookup (if_pc -> pred_taken/pred_target, zero latency),
//                  EX-stage update (upd_*), clear, mispredict flag and
//                  wrapping update/mispredict performance counters.
// ---------------------------------------------------------------------------
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int unsigned ENTRIES  = 64,
    parameter int unsigned XLEN     = 32,
    parameter logic [1:0]  CNT_INIT = 2'b01
) (
    input logic              clk,
    input logic              rst_n,
    branch_predictor_if.slave bp
);
    localparam int unsigned IDX  = bp_idx_w(ENTRIES);
    localparam int unsigned TAGW = bp_tag_w(XLEN, ENTRIES);

    logic            valid_q  [ENTRIES];
    logic            valid_d  [ENTRIES];
    bp_cnt_e         cnt_q    [ENTRIES];
    bp_cnt_e         cnt_d    [ENTRIES];
    logic [TAGW-1:0] tag_q    [ENTRIES];
    logic [TAGW-1:0] tag_d    [ENTRIES];
    logic [XLEN-1:0] target_q [ENTRIES];
    logic [XLEN-1:0] target_d [ENTRIES];

    logic [31:0] update_count_q, update_count_d;
    logic [31:0] mispredict_count_q, mispredict_count_d;

    logic [IDX-1:0]  lk_idx, up_idx;
    logic [TAGW-1:0] lk_tag, up_tag;
    logic            lk_hit, up_hit;
    bp_cnt_e         cnt_nxt;
    logic            cnt_inc, cnt_dec, cnt_load;
    bp_cnt_e         cnt_load_val;
    logic            unused_pc_lsbs;

    assign unused_pc_lsbs = &{1'b0, bp.if_pc[1:0], bp.upd_pc[1:0]};

    // Lookup reads registered state only, so a same-cycle update is not seen.
    always_comb begin
        lk_idx         = bp.if_pc[IDX+1:2];
        lk_tag         = bp.if_pc[XLEN-1:IDX+2];
        lk_hit         = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        bp.pred_taken  = lk_hit && cnt_q[lk_idx][1];
        bp.pred_target = bp.pred_taken ? target_q[lk_idx] : '0;
    end

    always_comb begin
        up_idx       = bp.upd_pc[IDX+1:2];
        up_tag       = bp.upd_pc[XLEN-1:IDX+2];
        up_hit       = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
        // Jumps pin the counter to ST; a taken miss allocates at WT.
        cnt_load     = bp.upd_is_jump || (bp.upd_taken && !up_hit);
        cnt_load_val = bp.upd_is_jump ? ST : WT;
        cnt_inc      = bp.upd_taken && up_hit;
        cnt_dec      = !bp.upd_taken && up_hit;
    end

    bp_sat_counter u_sat_counter (
        .cnt_i    (cnt_q[up_idx]),
        .inc      (cnt_inc),
        .dec      (cnt_dec),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .cnt_o    (cnt_nxt)
    );

    always_comb begin
        bp.mispredict = bp.upd_valid &&
                        ((bp.upd_taken != bp.upd_pred_taken) ||
                         (bp.upd_taken && (bp.upd_target != bp.upd_pred_target)));
        update_count_d     = update_count_q + (bp.upd_valid ? 32'd1 : 32'd0);
        mispredict_count_d = mispredict_count_q + (bp.mispredict ? 32'd1 : 32'd0);
        bp.update_count     = update_count_q;
        bp.mispredict_count = mispredict_count_q;
    end

    // Clear has priority; not-taken misses never allocate.
    always_comb begin
        valid_d  = valid_q;
        cnt_d    = cnt_q;
        tag_d    = tag_q;
        target_d = target_q;
        if (bp.clear) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                valid_d[i] = 1'b0;
                cnt_d[i]   = bp_cnt_e'(CNT_INIT);
            end
        end else if (bp.upd_valid) begin
            if (bp.upd_taken) begin
                valid_d[up_idx]  = 1'b1;
                tag_d[up_idx]    = up_tag;
                target_d[up_idx] = bp.upd_target;
                cnt_d[up_idx]    = cnt_nxt;
            end else if (up_hit) begin
                cnt_d[up_idx]    = cnt_nxt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                cnt_q[i]   <= bp_cnt_e'(CNT_INIT);
            end
            update_count_q     <= '0;
            mispredict_count_q <= '0;
        end else begin
            valid_q            <= valid_d;
            cnt_q              <= cnt_d;
            update_count_q     <= update_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    // Tag/target are only observable through a valid bit, so no reset needed.
    always_ff @(posedge clk) begin
        tag_q    <= tag_d;
        target_q <= target_d;
    end
endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;
    localparam int unsigned ENTRIES = 64;
    localparam int unsigned XLEN    = 32;

    logic clk;
    logic rst_n;

    branch_predictor_if #(.XLEN(XLEN)) bp ();

    branch_predictor #(
        .ENTRIES  (ENTRIES),
        .XLEN     (XLEN),
        .CNT_INIT (2'b01)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bp    (bp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: one slot per index holding the full word address.
    bit          m_valid [ENTRIES];
    logic [31:0] m_word  [ENTRIES];
    int          m_cnt   [ENTRIES];
    logic [31:0] m_tgt   [ENTRIES];
    logic [31:0] m_ucnt, m_mcnt;

    typedef struct {
        logic        pt;
        logic [31:0] ptgt;
        logic        misp;
        logic [31:0] uc;
        logic [31:0] mc;
    } exp_t;
    exp_t sb[$];

    function automatic void cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 1'b0;
            m_cnt[i]   = 1;
        end
        m_ucnt = 0;
        m_mcnt = 0;
    endfunction

    function automatic int m_idx(input logic [31:0] pc);
        return int'((pc >> 2) % ENTRIES);
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        int i = m_idx(pc);
        return m_valid[i] && (m_word[i] == (pc >> 2));
    endfunction

    function automatic void m_lookup(input logic [31:0] pc, output logic t, output logic [31:0] tg);
        int i = m_idx(pc);
        t  = m_hit(pc) && (m_cnt[i] >= 2);
        tg = t ? m_tgt[i] : 32'h0;
    endfunction

    task automatic step(input logic [31:0] ipc, input logic uv, input logic [31:0] upc,
                        input logic ut, input logic [31:0] utgt, input logic uj,
                        input logic upt, input logic [31:0] uptgt, input logic clr);
        exp_t e;
        int   i;
        bit   hit;
        @(negedge clk);
        bp.if_pc           = ipc;
        bp.upd_valid       = uv;
        bp.upd_pc          = upc;
        bp.upd_taken       = ut;
        bp.upd_target      = utgt;
        bp.upd_is_jump     = uj;
        bp.upd_pred_taken  = upt;
        bp.upd_pred_target = uptgt;
        bp.clear           = clr;
        m_lookup(ipc, e.pt, e.ptgt);
        e.misp = uv && ((ut != upt) || (ut && (utgt != uptgt)));
        e.uc   = m_ucnt;
        e.mc   = m_mcnt;
        sb.push_back(e);
        if (rst_n) begin
            if (uv) m_ucnt++;
            if (e.misp) m_mcnt++;
            if (clr) begin
                for (int k = 0; k < ENTRIES; k++) begin
                    m_valid[k] = 1'b0;
                    m_cnt[k]   = 1;
                end
            end else if (uv) begin
                i   = m_idx(upc);
                hit = m_hit(upc);
                if (ut) begin
                    if (uj)       m_cnt[i] = 3;
                    else if (hit) m_cnt[i] = (m_cnt[i] == 3) ? 3 : m_cnt[i] + 1;
                    else          m_cnt[i] = 2;
                    m_valid[i] = 1'b1;
                    m_word[i]  = upc >> 2;
                    m_tgt[i]   = utgt;
                end else if (hit) begin
                    if (uj) m_cnt[i] = 3;
                    else    m_cnt[i] = (m_cnt[i] == 0) ? 0 : m_cnt[i] - 1;
                end
            end
        end
    endtask

    task automatic idle(input logic [31:0] ipc);
        step(ipc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    // Monitor: outputs are combinational, so every driven cycle is checked
    // mid-way between the driving negedge and the next posedge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                cmp("pred_taken",       {31'h0, bp.pred_taken}, {31'h0, e.pt});
                cmp("pred_target",      bp.pred_target,         e.ptgt);
                cmp("mispredict",       {31'h0, bp.mispredict}, {31'h0, e.misp});
                cmp("update_count",     bp.update_count,        e.uc);
                cmp("mispredict_count", bp.mispredict_count,    e.mc);
            end
        end
    end

    function automatic logic [31:0] rand_pc();
        logic [31:0] t = $urandom_range(0, 3);
        logic [31:0] x = $urandom_range(0, 7);
        logic [31:0] l = $urandom_range(0, 3);
        return (t << 8) | (x << 2) | l;
    endfunction

    initial begin
        logic        pt;
        logic [31:0] ptg, upc, utgt;
        logic        uv, ut, uj, upt, clr;

        rst_n = 1'b0;
        bp.if_pc = '0; bp.upd_valid = 1'b0; bp.upd_pc = '0; bp.upd_taken = 1'b0;
        bp.upd_target = '0; bp.upd_is_jump = 1'b0; bp.upd_pred_taken = 1'b0;
        bp.upd_pred_target = '0; bp.clear = 1'b0;
        m_reset();

        // Reset state, lookup of 0x100
        idle(32'h100);
        idle(32'h100);
        #3;
        cmp("rst_pred_taken",  {31'h0, bp.pred_taken}, 32'h0);
        cmp("rst_pred_target", bp.pred_target, 32'h0);
        cmp("rst_update_cnt",  bp.update_count, 32'h0);
        cmp("rst_misp_cnt",    bp.mispredict_count, 32'h0);
        rst_n = 1'b1;

        // Allocate 0x100 -> 0x200, then hit
        step(32'h100, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 1'b0, 32'h0, 1'b0);
        idle(32'h100);
        #3;
        cmp("alloc_pred_taken",  {31'h0, bp.pred_taken}, 32'h1);
        cmp("alloc_pred_target", bp.pred_target, 32'h200);

        // Counter 2 -> 1 -> 0 -> 0, then one taken brings it to 1 (still not-taken)
        step(32'h100, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 1'b1, 32'h200, 1'b0);
        step(32'h100, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        idle(32'h100);
        #3;
        cmp("dec_pred_taken", {31'h0, bp.pred_taken}, 32'h0);
        step(32'h100, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        step(32'h100, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 1'b0, 32'h0, 1'b0);
        idle(32'h100);
        #3;
        cmp("sat0_pred_taken", {31'h0, bp.pred_taken}, 32'h0);

        // Alias at index 0: 0x200 misses, replaces, then 0x100 misses
        step(32'h100, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 1'b0, 32'h0, 1'b0);
        idle(32'h200);
        #3;
        cmp("alias_miss", {31'h0, bp.pred_taken}, 32'h0);
        // Same-cycle lookup of the index being replaced sees the old entry
        step(32'h100, 1'b1, 32'h200, 1'b1, 32'h300, 1'b0, 1'b0, 32'h0, 1'b0);
        #3;
        cmp("nobypass_target", bp.pred_target, 32'h200);
        idle(32'h100);
        #3;
        cmp("alias_old_miss", {31'h0, bp.pred_taken}, 32'h0);
        idle(32'h200);
        #3;
        cmp("alias_new_target", bp.pred_target, 32'h300);

        // Reset asserted in the middle of an update cycle aborts the write
        @(negedge clk);
        bp.upd_valid = 1'b1; bp.upd_pc = 32'h40; bp.upd_taken = 1'b1;
        bp.upd_target = 32'h80; bp.if_pc = 32'h40;
        #1;
        rst_n = 1'b0;
        m_reset();
        #1;
        bp.upd_valid = 1'b0; bp.upd_taken = 1'b0;
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        idle(32'h40);
        #3;
        cmp("rst_abort_pred", {31'h0, bp.pred_taken}, 32'h0);
        cmp("rst_abort_ucnt", bp.update_count, 32'h0);

        // JAL with clear in the same cycle: dropped, but counted
        step(32'h40, 1'b1, 32'h40, 1'b1, 32'h80, 1'b1, 1'b0, 32'h0, 1'b1);
        #3;
        cmp("clr_jal_misp", {31'h0, bp.mispredict}, 32'h1);
        idle(32'h40);
        #3;
        cmp("clr_jal_pred", {31'h0, bp.pred_taken}, 32'h0);
        cmp("clr_jal_ucnt", bp.update_count, 32'h1);

        // Counter wrap via forced preload
        idle(32'h0);
        #3;
        force dut.mispredict_count_q = 32'hFFFF_FFFF;
        force dut.update_count_q     = 32'hFFFF_FFFF;
        #1;
        release dut.mispredict_count_q;
        release dut.update_count_q;
        m_mcnt = 32'hFFFF_FFFF;
        m_ucnt = 32'hFFFF_FFFF;
        step(32'h0, 1'b1, 32'h44, 1'b1, 32'h88, 1'b0, 1'b0, 32'h0, 1'b0);
        idle(32'h0);
        #3;
        cmp("wrap_misp_cnt", bp.mispredict_count, 32'h0);
        cmp("wrap_upd_cnt",  bp.update_count, 32'h0);

        // Randomized traffic against the model
        for (int n = 0; n < 1500; n++) begin
            uv   = ($urandom_range(0, 3) != 0);
            upc  = rand_pc();
            uj   = ($urandom_range(0, 7) == 0);
            ut   = uj ? 1'b1 : ($urandom_range(0, 1) == 1);
            utgt = $urandom & 32'h0000_0FFC;
            clr  = ($urandom_range(0, 49) == 0);
            m_lookup(upc, pt, ptg);
            if ($urandom_range(0, 3) != 0) begin
                upt = pt;
            end else begin
                upt = ($urandom_range(0, 1) == 1);
                ptg = $urandom & 32'h0000_0FFC;
            end
            step(rand_pc(), uv, upc, ut, utgt, uj, upt, ptg, clr);
        end

        idle(32'h0);
        @(negedge clk);
        #3;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
